dmem_apb_resp: RTL

//   APB-style responder for the data-memory region (0x000-0x3FF) on the LSU's peripheral-bus side.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_byte_ram.sv | 27 ++
 rtl/dmem_apb_resp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory APB responder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  typedef logic [3:0][7:0] word_t;

  // Replace only the lanes whose enable bit is set.
  function automatic word_t merge_lanes(input word_t old_word, input word_t new_word,
                                        input logic [STRB_W-1:0] lane_en);
    word_t merged;
    for (int i = 0; i < STRB_W; i++) begin
      merged[i] = lane_en[i] ? new_word[i] : old_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with independent byte-lane write enables and a
// combinational read port. Contents have no reset and survive rst_ni.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic [STRB_W-1:0] lane_we,
  input  logic [AW-1:0]     addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [DEPTH_WORDS];

  // Lane-masked write; unselected lanes keep their previous contents.
  always_ff @(posedge clk) begin
    if (|lane_we) begin
      mem[addr] <= merge_lanes(mem[addr], wdata, lane_we);
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_apb_resp.sv
// APB-style responder for the data-memory region. Latches the request in the
// setup phase, counts programmable wait states, then commits and raises
// pready_o for a single cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; a setup phase (psel & !penable) latches request
// WAIT  | counting wait states; psel drop aborts, cnt==0 commits
// DONE  | pready_o high for this one cycle, then back to IDLE
module dmem_apb_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYC    = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  input  logic [STRB_W-1:0] pstrb_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int RAM_AW = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [3:0]     WAIT_INIT = 4'(WAIT_CYC);

  dmem_state_e state_q, state_nxt;

  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  word_t             wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [3:0]        cnt_q, cnt_nxt;

  logic              pready_q, pready_nxt;
  logic              pslverr_q, pslverr_nxt;
  logic [DATA_W-1:0] prdata_q, prdata_nxt;

  logic              latch_en;
  logic              err;
  logic [STRB_W-1:0] lane_we;
  word_t             ram_rdata;

  // Byte offset bits never select memory; lanes come from pstrb_i alone.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^paddr_i[1:0];

  assign err = ({1'b0, idx_q} >= DEPTH_LIM);

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (RAM_AW)
  ) u_ram (
    .clk     (clk_i),
    .lane_we (lane_we),
    .addr    (idx_q[RAM_AW-1:0]),
    .wdata   (wdata_q),
    .rdata   (ram_rdata)
  );

  // State register; reset drops any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: psel_i drop in WAIT takes priority over commit.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: if (psel_i && !penable_i) state_nxt = WAIT;
      WAIT: begin
        if (!psel_i)             state_nxt = IDLE;
        else if (cnt_q == 4'd0)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath decode: latch enable, wait count, commit and response values.
  always_comb begin
    latch_en    = 1'b0;
    cnt_nxt     = cnt_q;
    lane_we     = '0;
    pready_nxt  = pready_q;
    pslverr_nxt = pslverr_q;
    prdata_nxt  = prdata_q;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          latch_en = 1'b1;
          cnt_nxt  = WAIT_INIT;
        end
      end
      WAIT: begin
        if (psel_i) begin
          if (cnt_q != 4'd0) begin
            cnt_nxt = cnt_q - 4'd1;
          end else begin
            pready_nxt  = 1'b1;
            pslverr_nxt = err;
            if (write_q) begin
              if (!err) lane_we = strb_q;
            end else begin
              prdata_nxt = err ? '0 : ram_rdata;
            end
          end
        end
      end
      DONE: begin
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Request latches, wait counter and registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      if (latch_en) begin
        idx_q   <= paddr_i[ADDR_W-1:2];
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        strb_q  <= pstrb_i;
      end
      cnt_q     <= cnt_nxt;
      pready_q  <= pready_nxt;
      pslverr_q <= pslverr_nxt;
      prdata_q  <= prdata_nxt;
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

endmodule
